// File: rtl/c4_pkg.sv
// Shared types, board defaults, winner codes and the direction-step table
// for the Connect-Four controller.
package c4_pkg;

   localparam int C4_COLS = 7;
   localparam int C4_ROWS = 6;

   typedef enum logic [1:0] {
      CELL_EMPTY = 2'b00,
      CELL_P1    = 2'b01,
      CELL_P2    = 2'b10
   } cell_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PLACE,
      ST_CHECK,
      ST_GAMEOVER
   } state_t;

   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_P1   = 2'b01;
   localparam logic [1:0] WIN_P2   = 2'b10;
   localparam logic [1:0] WIN_DRAW = 2'b11;

   // Scan order: 0 horizontal, 1 vertical, 2 diagonal, 3 anti-diagonal.
   function automatic logic signed [4:0] dir_dcol(input logic [1:0] dir);
      return (dir == 2'd1) ? 5'sd0 : 5'sd1;
   endfunction

   function automatic logic signed [4:0] dir_drow(input logic [1:0] dir);
      case (dir)
         2'd0:    return 5'sd0;
         2'd3:    return -5'sd1;
         default: return 5'sd1;
      endcase
   endfunction

endpackage

// File: rtl/c4_line_scan.sv
// Walks outward from the last placed cell one probe per cycle, counting
// contiguous same-colour cells per direction; flags a line of four.
module c4_line_scan
   import c4_pkg::*;
(
   input  logic              clk_25MHz,
   input  logic              rst_n,
   input  logic              start,
   input  logic              enable,
   input  logic [2:0]        origin_col,
   input  logic [2:0]        origin_row,
   input  logic              probe_hit,
   output logic signed [4:0] probe_col,
   output logic signed [4:0] probe_row,
   output logic              done,
   output logic              win
);

   logic [1:0]        dir_q;
   logic              side_q;
   logic [1:0]        step_q;
   logic [2:0]        count_q;
   logic [2:0]        count_next;
   logic              side_end;
   logic signed [4:0] step_s;
   logic signed [4:0] off_col;
   logic signed [4:0] off_row;

   always_comb begin
      step_s  = $signed({3'b000, step_q});
      off_col = step_s * dir_dcol(dir_q);
      off_row = step_s * dir_drow(dir_q);
      if (side_q) begin
         off_col = -off_col;
         off_row = -off_row;
      end
      probe_col = $signed({2'b00, origin_col}) + off_col;
      probe_row = $signed({2'b00, origin_row}) + off_row;
   end

   // A side ends on a miss or after three steps; the placed cell itself seeds count at 1.
   always_comb begin
      count_next = count_q + {2'b00, probe_hit};
      side_end   = !probe_hit || (step_q == 2'd3);
      win        = enable && probe_hit && (count_next >= 3'd4);
      done       = win || (enable && side_end && side_q && (dir_q == 2'd3));
   end

   always_ff @(posedge clk_25MHz) begin
      if (!rst_n || start) begin
         dir_q   <= 2'd0;
         side_q  <= 1'b0;
         step_q  <= 2'd1;
         count_q <= 3'd1;
      end else if (enable && !done) begin
         if (!side_end) begin
            step_q  <= step_q + 2'd1;
            count_q <= count_next;
         end else if (!side_q) begin
            side_q  <= 1'b1;
            step_q  <= 2'd1;
            count_q <= count_next;
         end else begin
            dir_q   <= dir_q + 2'd1;
            side_q  <= 1'b0;
            step_q  <= 2'd1;
            count_q <= 3'd1;
         end
      end
   end

endmodule

// File: rtl/c4_game_ctrl.sv
// Connect-Four game controller: cursor, drop, win/draw detection and restart.
// Define C4_BTN_SYNC_EN to synchronise and edge-detect the button inputs.
module c4_game_ctrl
   import c4_pkg::*;
#(
   parameter int COLS = C4_COLS,
   parameter int ROWS = C4_ROWS
)
(
   input  logic       clk_25MHz,
   input  logic       rst_n,
   input  logic       move_left,
   input  logic       move_right,
   input  logic       drop_piece,
   input  logic [2:0] rd_col,
   input  logic [2:0] rd_row,
   output logic [1:0] rd_cell,
   output logic [2:0] cursor_col,
   output logic       cur_player,
   output logic       busy,
   output logic       game_over,
   output logic [1:0] winner
);

   localparam logic [2:0]        HOME_COL = 3'(COLS / 2);
   localparam logic [2:0]        MAX_COL  = 3'(COLS - 1);
   localparam logic [3:0]        COLS_H   = 4'(COLS);
   localparam logic [3:0]        ROWS_H   = 4'(ROWS);
   localparam logic signed [4:0] COLS_S   = 5'(COLS);
   localparam logic signed [4:0] ROWS_S   = 5'(ROWS);
   localparam logic [6:0]        CELLS    = 7'(COLS * ROWS);

   state_t     state_q, state_d;
   cell_t      board_q [COLS][ROWS];
   logic [3:0] height_q [COLS];
   logic [6:0] move_count_q;
   logic [2:0] cursor_q;
   logic [2:0] place_row_q;
   logic       player_q;
   logic [1:0] winner_q;

   logic              left_req, right_req, drop_req;
   logic [3:0]        col_height;
   cell_t             colour;
   logic signed [4:0] probe_col, probe_row;
   logic              probe_hit, scan_done, scan_win, restart;

`ifdef C4_BTN_SYNC_EN
   logic [2:0] sync1_q, sync2_q, prev_q;

   // Two-flop synchroniser then rising-edge detect: one request per press.
   always_ff @(posedge clk_25MHz) begin
      if (!rst_n) begin
         sync1_q <= 3'b000;
         sync2_q <= 3'b000;
         prev_q  <= 3'b000;
      end else begin
         sync1_q <= {move_left, move_right, drop_piece};
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   assign {left_req, right_req, drop_req} = sync2_q & ~prev_q;
`else
   assign {left_req, right_req, drop_req} = {move_left, move_right, drop_piece};
`endif

   assign col_height = height_q[cursor_q];
   assign colour     = player_q ? CELL_P2 : CELL_P1;
   assign restart    = (state_q == ST_GAMEOVER) && drop_req;

   always_comb begin
      probe_hit = 1'b0;
      if (probe_col >= 5'sd0 && probe_col < COLS_S && probe_row >= 5'sd0 && probe_row < ROWS_S)
         probe_hit = (board_q[probe_col[2:0]][probe_row[2:0]] == colour);
   end

   c4_line_scan u_line_scan (
      .clk_25MHz  (clk_25MHz),
      .rst_n      (rst_n),
      .start      (state_q == ST_PLACE),
      .enable     (state_q == ST_CHECK),
      .origin_col (cursor_q),
      .origin_row (place_row_q),
      .probe_hit  (probe_hit),
      .probe_col  (probe_col),
      .probe_row  (probe_row),
      .done       (scan_done),
      .win        (scan_win)
   );

   always_ff @(posedge clk_25MHz) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:     if (drop_req && col_height < ROWS_H) state_d = ST_PLACE;
         ST_PLACE:    state_d = ST_CHECK;
         ST_CHECK:    if (scan_done)
                         state_d = (scan_win || move_count_q == CELLS) ? ST_GAMEOVER : ST_IDLE;
         ST_GAMEOVER: if (drop_req) state_d = ST_IDLE;
         default:     state_d = ST_IDLE;
      endcase
   end

   // A restart from GAMEOVER clears exactly what reset clears.
   always_ff @(posedge clk_25MHz) begin
      if (!rst_n || restart) begin
         for (int c = 0; c < COLS; c++) begin
            height_q[c] <= 4'd0;
            for (int r = 0; r < ROWS; r++) board_q[c][r] <= CELL_EMPTY;
         end
         move_count_q <= 7'd0;
         cursor_q     <= HOME_COL;
         place_row_q  <= 3'd0;
         player_q     <= 1'b0;
         winner_q     <= WIN_NONE;
      end else begin
         case (state_q)
            ST_IDLE: if (!drop_req && (left_req ^ right_req)) begin
               if (left_req && cursor_q != 3'd0)          cursor_q <= cursor_q - 3'd1;
               else if (right_req && cursor_q != MAX_COL) cursor_q <= cursor_q + 3'd1;
            end
            ST_PLACE: begin
               board_q[cursor_q][col_height[2:0]] <= colour;
               height_q[cursor_q] <= col_height + 4'd1;
               move_count_q       <= move_count_q + 7'd1;
               place_row_q        <= col_height[2:0];
            end
            ST_CHECK: if (scan_done) begin
               if (scan_win)                   winner_q <= player_q ? WIN_P2 : WIN_P1;
               else if (move_count_q == CELLS) winner_q <= WIN_DRAW;
               else                            player_q <= ~player_q;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      rd_cell = CELL_EMPTY;
      if ({1'b0, rd_col} < COLS_H && {1'b0, rd_row} < ROWS_H)
         rd_cell = board_q[rd_col][rd_row];
   end

   assign cursor_col = cursor_q;
   assign cur_player = player_q;
   assign busy       = (state_q == ST_PLACE) || (state_q == ST_CHECK);
   assign game_over  = (state_q == ST_GAMEOVER);
   assign winner     = winner_q;

endmodule

// File: doc/c4_game_ctrl.md
C4_GAME_CTRL -- requirements
Module: c4_game_ctrl

Interface
REQ-001 SHALL have parameter COLS, default 7: number of board columns (max 8).
REQ-002 SHALL have parameter ROWS, default 6: number of board rows (max 8).
REQ-003 SHALL have port clk_25MHz, input, 1 bit: the only clock.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have ports move_left, move_right, drop_piece, input, 1 bit each: button requests.
REQ-006 SHALL have ports rd_col and rd_row, input, 3 bits each: renderer read address; row 0 is the bottom row.
REQ-007 SHALL have port rd_cell, output, 2 bits: cell contents; 00 empty, 01 player 1, 10 player 2.
REQ-008 SHALL have port cursor_col, output, 3 bits: the selected column.
REQ-009 SHALL have port cur_player, output, 1 bit: 0 means player 1 to move, 1 means player 2.
REQ-010 SHALL have port busy, output, 1 bit: high in PLACE or CHECK.
REQ-011 SHALL have port game_over, output, 1 bit: high in GAMEOVER.
REQ-012 SHALL have port winner, output, 2 bits: 00 none, 01 player 1, 10 player 2, 11 draw.

Function
REQ-013 SHALL implement an FSM with the states IDLE, PLACE, CHECK and GAMEOVER.
REQ-014 SHALL, in IDLE on move_left, decrement cursor_col, saturating at 0.
REQ-015 SHALL, in IDLE on move_right, increment cursor_col, saturating at COLS-1.
REQ-016 SHALL ignore move_left and move_right when both are asserted in the same cycle.
REQ-017 SHALL give drop_piece priority over the move buttons in the same cycle; cursor_col stays unchanged.
REQ-018 SHALL, in IDLE on drop_piece when height[cursor_col] < ROWS, enter PLACE next cycle.
REQ-019 SHALL ignore drop_piece on a full column: no state change, cur_player unchanged.
REQ-020 SHALL, in PLACE (1 cycle), write the cur_player colour at (cursor_col, height[cursor_col]), increment that height and the move count, then enter CHECK.
REQ-021 SHALL, in CHECK, scan outward from the placed cell in four directions (horizontal, vertical, diagonal, anti-diagonal), at most 3 cells each way.
REQ-022 SHALL check one cell per cycle during CHECK and stop scanning a side at the board edge or at a cell not of the current colour.
REQ-023 SHALL treat a contiguous count >= 4 as a win: enter GAMEOVER with winner = cur_player+1; early exit is allowed.
REQ-024 SHALL complete CHECK in at most 24 cycles.
REQ-025 SHALL, on no win when move count = COLS*ROWS, enter GAMEOVER with winner = 11.
REQ-026 SHALL, on no win otherwise, toggle cur_player and return to IDLE.
REQ-027 SHALL ignore all buttons while busy is high; presses are not queued.
REQ-028 SHALL, in GAMEOVER, ignore the move buttons and, on drop_piece, start a new game: board and heights cleared, move count 0, cur_player 0, cursor_col 3 (COLS/2), winner 00, state IDLE, all in one cycle.
REQ-029 SHALL drive rd_cell combinationally from the registered board; out-of-range addresses read 00.

Reset
REQ-030 SHALL, with rst_n low at a clock edge, set: state IDLE, board empty, heights 0, move count 0, cursor_col COLS/2, cur_player 0, busy 0, game_over 0, winner 00.
REQ-031 SHALL, on reset asserted mid-PLACE or mid-CHECK, abandon the move with no partial update surviving.

Configuration
REQ-032 SHALL, with C4_BTN_SYNC_EN defined, pass each button through a 2-flop synchroniser plus rising-edge detector, so one press of any length is one request.
REQ-033 SHALL, without C4_BTN_SYNC_EN, treat each button as a synchronous single-cycle pulse; a level held N IDLE cycles counts as N requests.

Structure
REQ-034 SHALL take from package c4_pkg: COLS and ROWS defaults, the cell_t encoding, the FSM state enum, winner codes and the direction-step table.
REQ-035 SHALL place the direction/step counter and contiguous-count logic of CHECK in sub-module c4_line_scan.

Verification
REQ-036 SHALL cover reset: rst_n low 2 cycles -> cursor_col=3, cur_player=0, winner=00, all rd_cell=00.
REQ-037 SHALL cover cursor saturation: 4 move_left pulses -> cursor_col=0; then 9 move_right pulses -> cursor_col=6.
REQ-038 SHALL cover a vertical win: alternating drops in col 0 (P1) and col 1 (P2), 7 drops -> within 26 cycles of the 7th drop, game_over=1, winner=01, rd_cell(0,3)=01.
REQ-039 SHALL cover a full column: 6 drops in col 3, then a 7th -> state stays IDLE, cur_player unchanged, rd_cell(3,5)=10.
REQ-040 SHALL cover restart: drop_piece in GAMEOVER -> next cycle board empty, cur_player=0, winner=00, game_over=0.
REQ-041 SHALL cover input handling: with C4_BTN_SYNC_EN, drop_piece held 40 cycles -> exactly one piece placed; move_left+move_right together -> cursor unchanged.
